// File: rtl/serial_add_arbiter.sv
// Two-requester round-robin front end feeding one shared bit-serial full-add cell.
// Operands are added LSB-first over WIDTH cycles; the result is held until the consumer takes it.
module serial_add_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_id,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // Ready never depends on the same channel's data, only on state, arbitration and valid.
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_sum_sh;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic               r_cout;
  logic               r_id;
  logic               r_last;

  logic               w_idle;
  logic               w_grant_id;
  logic               w_accept;
  logic               w_cnt_last;
  logic               w_p;
  logic               w_s;
  logic               w_c_next;

  // A tie goes to whoever was not served last; a lone request always wins.
  assign w_idle      = (r_state == ST_IDLE);
  assign w_grant_id  = (req0_valid & req1_valid) ? ~r_last : req1_valid;
  assign req0_ready  = w_idle & req0_valid & ~w_grant_id;
  assign req1_ready  = w_idle & req1_valid & w_grant_id;
  assign w_accept    = req0_ready | req1_ready;
  assign w_cnt_last  = (r_cnt == CNT_LAST);

  // Two cascaded half adders plus an OR form the full-add cell.
  assign w_p      = r_a_sh[0] ^ r_b_sh[0];
  assign w_s      = w_p ^ r_carry;
  assign w_c_next = (r_a_sh[0] & r_b_sh[0]) | (r_carry & w_p);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept)   w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_cnt_last) w_state_nxt = ST_DONE;
      ST_DONE:  if (res_ready)  w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_id     <= 1'b0;
      r_last   <= 1'b1;
    end else if (w_accept) begin
      r_a_sh   <= w_grant_id ? req1_a : req0_a;
      r_b_sh   <= w_grant_id ? req1_b : req0_b;
      r_sum_sh <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_id     <= w_grant_id;
      r_last   <= w_grant_id;
    end else if (r_state == ST_SHIFT) begin
      // Sum bits enter at the MSB so the word is LSB-aligned after WIDTH shifts.
      r_sum_sh <= {w_s, r_sum_sh[WIDTH-1:1]};
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      r_carry  <= w_c_next;
      if (w_cnt_last) begin
        r_cnt  <= '0;
        r_cout <= w_c_next;
      end else begin
        r_cnt  <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign res_valid = (r_state == ST_DONE);
  assign res_sum   = r_sum_sh;
  assign res_cout  = r_cout;
  assign res_id    = r_id;
  assign busy      = (r_state == ST_SHIFT) | (r_state == ST_DONE);
  assign state_dbg = r_state;

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Bench for serial_add_arbiter: directed corner cases then randomized traffic,
// checked against an arithmetic (a+b) model with a round-robin grant model.
module tb_serial_add_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         res_valid, res_ready;
  logic [W-1:0] res_sum;
  logic         res_cout, res_id, busy;
  logic [1:0]   state_dbg;

  serial_add_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_cout   (res_cout),
    .res_id     (res_id),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int model_last;
  logic [W+1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at a falling edge with res_valid expected high; leaves #1 after the handshake edge.
  task automatic collect(input int stall);
    logic [W+1:0] e;
    if (exp_q.size() == 0) begin
      check("queue_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check("res_sum", res_sum, e[W-1:0]);
    check("res_cout", res_cout, e[W]);
    check("res_id", res_id, e[W+1]);
    res_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_valid", res_valid, 1);
      check("stall_sum", res_sum, e[W-1:0]);
      check("stall_cout", res_cout, e[W]);
      check("stall_id", res_id, e[W+1]);
      check("stall_readies", {req0_ready, req1_ready}, 0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check("valid_drop", res_valid, 0);
    check("busy_drop", busy, 0);
  endtask

  // One full operation using whatever the requesters currently present.
  task automatic do_op(input bit keep, input int stall);
    int exp_id, waits, gid, lat;
    logic [W-1:0] ea, eb;
    logic [W:0] full;
    if (req0_valid && req1_valid) exp_id = 1 - model_last;
    else exp_id = req1_valid ? 1 : 0;
    waits = 0;
    @(negedge clk);
    while (!(req0_ready || req1_ready) && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    check("accept_wait", waits, 0);
    if (!(req0_ready || req1_ready)) return;
    gid = req1_ready ? 1 : 0;
    check("grant_id", gid, exp_id);
    check("one_ready", {31'b0, req0_ready & req1_ready}, 0);
    ea = (exp_id == 1) ? req1_a : req0_a;
    eb = (exp_id == 1) ? req1_b : req0_b;
    full = {1'b0, ea} + {1'b0, eb};
    exp_q.push_back({exp_id[0], full});
    model_last = exp_id;
    @(posedge clk);
    #1;
    if (exp_id == 1) begin
      if (keep) begin req1_a = W'($urandom); req1_b = W'($urandom); end
      else req1_valid = 1'b0;
    end else begin
      if (keep) begin req0_a = W'($urandom); req0_b = W'($urandom); end
      else req0_valid = 1'b0;
    end
    check("busy_shift", busy, 1);
    check("valid_shift", res_valid, 0);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!res_valid && lat < 3 * W);
    check("latency", lat, W);
    if (!res_valid) begin
      void'(exp_q.pop_front());
      return;
    end
    collect(stall);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waits;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    res_ready = 1'b0;
    model_last = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", state_dbg, 0);
    check("rst_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", res_sum, 0);
    check("rst_cout", res_cout, 0);
    check("rst_id", res_id, 0);
    check("rst_readies", {req0_ready, req1_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed sums.
    req0_a = 8'h5A; req0_b = 8'h3C; req0_valid = 1'b1;
    do_op(0, 0);
    req1_a = 8'hFF; req1_b = 8'h01; req1_valid = 1'b1;
    do_op(0, 0);
    req1_a = 8'hFF; req1_b = 8'hFF; req1_valid = 1'b1;
    do_op(0, 0);

    // Continuous dual requests: grants must alternate.
    req0_a = W'($urandom); req0_b = W'($urandom); req0_valid = 1'b1;
    req1_a = W'($urandom); req1_b = W'($urandom); req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) do_op(1, 0);

    // Backpressure with both requesters still asking.
    do_op(1, 5);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Reset in the middle of SHIFT discards the operation.
    req1_a = 8'h55; req1_b = 8'h22; req1_valid = 1'b1;
    @(negedge clk);
    check("pre_rst_ready", req1_ready, 1);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", state_dbg, 0);
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_sum", res_sum, 0);
    check("mid_rst_cout", res_cout, 0);
    check("mid_rst_id", res_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1;
    waits = 0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      if (res_valid) waits++;
    end
    check("no_result_after_rst", waits, 0);
    @(posedge clk);
    #1;
    req0_a = 8'h01; req0_b = 8'h01; req0_valid = 1'b1;
    req1_a = 8'h77; req1_b = 8'h10; req1_valid = 1'b1;
    do_op(0, 0);
    req1_valid = 1'b0;

    // Randomized traffic with random result stalls.
    for (int n = 0; n < 1000; n++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      if (!req0_valid && !req1_valid) req0_valid = 1'b1;
      req0_a = W'($urandom); req0_b = W'($urandom);
      req1_a = W'($urandom); req1_b = W'($urandom);
      do_op(1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_add_arbiter.md
# serial_add_arbiter

Shared bit-serial adder with a two-requester round-robin arbiter. It uses one half-adder-pair full-add cell to add WIDTH-bit operands LSB-first over WIDTH cycles. Requesters 0 and 1 present operands on valid/ready channels. The block grants one requester at a time, runs the serial addition, and returns sum, carry-out and requester ID on a single valid/ready result channel. It sits between operand-producing logic and the shared adder resource, trading latency for area.

## Interface
- WIDTH, 8, operand and sum width in bits (≥2)
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- req0_valid  input  1  requester 0 operands valid
- req0_ready  output  1  requester 0 accepted this cycle
- req0_a, req0_b  input  WIDTH  requester 0 operands
- req1_valid  input  1  requester 1 operands valid
- req1_ready  output  1  requester 1 accepted this cycle
- req1_a, req1_b  input  WIDTH  requester 1 operands
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_sum  output  WIDTH  (a+b) mod 2^WIDTH
- res_cout  output  1  carry out of bit WIDTH-1
- res_id  output  1  requester that owns the result
- busy  output  1  high in SHIFT and DONE

## Operation
- States:
  - IDLE: waiting for a request.
  - SHIFT: counter runs 0..WIDTH-1.
  - DONE: holding the result.
- IDLE arbitration:
  - If only one reqN_valid is high, grant it.
  - If both are high, grant the requester not granted last (pointer `last`).
  - reqN_ready = (state==IDLE) & granted & reqN_valid. This is combinational, and at most one ready is high at a time.
- Accept (ready & valid at an edge):
  - Load shift registers a_sh, b_sh.
  - Clear carry, sum shift register and bit counter.
  - Latch res_id and set last to the granted ID.
  - Go to SHIFT.
- SHIFT, each cycle:
  - Compute s = a_sh[0]^b_sh[0]^c and c_next = (a_sh[0]&b_sh[0]) | (c&(a_sh[0]^b_sh[0])). These are two cascaded half adders plus an OR.
  - Shift s into the sum register MSB, which ends LSB-aligned after WIDTH shifts.
  - Shift a_sh and b_sh right by one.
  - Increment the counter.
  - At counter==WIDTH-1, register c_next as res_cout and go to DONE.
- DONE:
  - res_valid=1.
  - res_sum, res_cout and res_id are held stable until the res_ready handshake. The handshake then returns the block to IDLE.
- No new request is accepted outside IDLE. Requester inputs are ignored in SHIFT and DONE, so requesters must hold their data until ready.
- Arithmetic is unsigned modulo 2^WIDTH, with res_cout as bit WIDTH.

## Timing
- Reset values:
  - state=IDLE, res_valid=0, res_sum=0, res_cout=0, res_id=0, busy=0, counter=0.
  - last=1, so requester 0 wins the first tie.
- Accept at edge T:
  - SHIFT occupies the cycles after edges T..T+WIDTH-1.
  - res_valid rises after edge T+WIDTH.
  - Latency is WIDTH cycles from accept to res_valid.
- Result handshake at edge R:
  - res_valid falls after R.
  - The next accept can occur at edge R+1 at the earliest.
  - Minimum period per operation is WIDTH+2 cycles.
- Backpressure: while res_ready=0 the block stays in DONE indefinitely, with outputs constant and both readies low.
- Simultaneous requests:
  - Ties are broken only by `last`.
  - Under continuous dual requests, grants strictly alternate 0,1,0,1.
- Reset asserted mid-SHIFT or in DONE:
  - Immediately forces all reset values.
  - The in-flight operation is discarded and no result is produced.
- Counter wrap: the counter never exceeds WIDTH-1. The DONE transition occurs exactly on the WIDTH-th SHIFT cycle.

## Test plan
- WIDTH=8, req0 a=0x5A, b=0x3C: res_valid exactly 8 cycles after accept; sum=0x96, cout=0, id=0.
- req1 a=0xFF, b=0x01 → sum=0x00, cout=1, id=1. Also a=0xFF, b=0xFF → sum=0xFE, cout=1.
- Both requesters valid continuously for 4 operations: grants are 0,1,0,1, and each result's id matches the owner of its operands.
- Hold res_ready=0 for 5 cycles in DONE: res_valid, res_sum, res_cout and res_id stay constant, and req0_ready=req1_ready=0 throughout. Release res_ready: IDLE on the next edge, new accept one cycle later.
- Drop rst_n at SHIFT cycle 3: outputs go to reset values immediately. After release, a tie grants requester 0 and a fresh 0x01+0x01 gives sum 0x02, cout=0.
- Randomized: 1000 operand pairs with random res_ready stalls, checked against an (a+b) reference model.
